// File: rtl/icache_burst.sv
// Direct-mapped, read-only instruction cache with whole-line AXI INCR refill,
// invalidate-all flush and hit/miss counters.
module icache_burst #(
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4,
    parameter int AXI_ID     = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        flush,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,

    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,

    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);

    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int WRD_W = OFF_W - 2;
    localparam int BC_W  = (WRD_W > 0) ? WRD_W : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, AR, REFILL} state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } fetch_addr_t;

    state_t          state;
    fetch_addr_t     req_q;
    logic [SETS-1:0] valid;
    logic [TAG_W-1:0] tag_mem [SETS];
    logic [31:0]     data_mem [SETS][LINE_WORDS];

    logic [BC_W-1:0] beat_cnt;
    logic [BC_W-1:0] req_word;
    logic [31:0]     hold;
    logic            line_err;
    logic            flush_pend;

    logic            hit;
    logic            beat_fire;
    logic            beat_last;
    logic            fill_done;
    logic [5:0]      unused_in;

    // Single-word lines have no word-select field in the address.
    generate
        if (WRD_W > 0) begin : g_word
            assign req_word = req_q.off[OFF_W-1:2];
        end else begin : g_noword
            assign req_word = '0;
        end
    endgenerate

    assign unused_in = {RID, req_q.off[1:0]};

    assign hit       = valid[req_q.idx] && (tag_mem[req_q.idx] == req_q.tag);
    assign beat_fire = (state == REFILL) && RVALID && RREADY;
    assign beat_last = (beat_cnt == BC_W'(LINE_WORDS - 1));
    assign fill_done = beat_fire && (RLAST || beat_last);

    assign inst_sram_addr_ok = (state == IDLE) && !flush_pend && !flush;

    assign ARID    = 4'(AXI_ID);
    assign ARADDR  = {req_q.tag, req_q.idx, {OFF_W{1'b0}}};
    assign ARLEN   = 8'(LINE_WORDS - 1);
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;

    // Arrays carry no reset; valid bits alone decide whether contents count.
    always_ff @(posedge clk) begin
        if (!reset && beat_fire)
            data_mem[req_q.idx][beat_cnt] <= RDATA;
        if (!reset && fill_done)
            tag_mem[req_q.idx] <= req_q.tag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            req_q             <= '0;
            valid             <= '0;
            inst_sram_data_ok <= 1'b0;
            inst_sram_rdata   <= '0;
            ARVALID           <= 1'b0;
            RREADY            <= 1'b0;
            hit_cnt           <= '0;
            miss_cnt          <= '0;
            flush_pend        <= 1'b0;
            beat_cnt          <= '0;
            hold              <= '0;
            line_err          <= 1'b0;
        end else begin
            inst_sram_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush)
                        valid <= '0;
                    if (inst_sram_req && inst_sram_addr_ok) begin
                        req_q <= inst_sram_addr;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Hit test uses the pre-flush valid bits.
                    if (flush)
                        valid <= '0;
                    if (hit) begin
                        inst_sram_data_ok <= 1'b1;
                        inst_sram_rdata   <= data_mem[req_q.idx][req_word];
                        hit_cnt           <= hit_cnt + 32'd1;
                        state             <= IDLE;
                    end else begin
                        miss_cnt <= miss_cnt + 32'd1;
                        ARVALID  <= 1'b1;
                        state    <= AR;
                    end
                end
                AR: begin
                    if (flush)
                        flush_pend <= 1'b1;
                    if (ARREADY) begin
                        ARVALID  <= 1'b0;
                        RREADY   <= 1'b1;
                        beat_cnt <= '0;
                        line_err <= 1'b0;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush)
                        flush_pend <= 1'b1;
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (RRESP != 2'b00)
                            line_err <= 1'b1;
                        if (beat_cnt == req_word)
                            hold <= RDATA;
                    end
                    if (fill_done) begin
                        RREADY            <= 1'b0;
                        flush_pend        <= 1'b0;
                        inst_sram_data_ok <= 1'b1;
                        inst_sram_rdata   <= (beat_cnt == req_word) ? RDATA : hold;
                        state             <= IDLE;
                        // A flush seen anywhere in the refill wipes everything, this line included.
                        if (flush_pend || flush)
                            valid <= '0;
                        else if (!line_err && RRESP == 2'b00)
                            valid[req_q.idx] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_burst.sv
// Directed bench: three caches (4-, 1- and 16-word lines) each driven by a small AXI read slave.
module tb_icache_burst;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req[3], flush[3];
    logic [31:0] addr[3];
    logic        addr_ok[3], dok[3];
    logic [31:0] rd[3], hitc[3], missc[3];
    logic [3:0]  arid[3];
    logic [31:0] araddr[3];
    logic [7:0]  arlen[3];
    logic [2:0]  arsize[3];
    logic [1:0]  arburst[3];
    logic        arvalid[3], rready[3];

    logic        arready[3], rvalid[3], rlast[3];
    logic [31:0] rdata_s[3];
    logic [1:0]  rresp[3];

    // slave controls (written by the stimulus only)
    int          ar_delay[3], gap[3], err_beat[3];
    logic [31:0] base[3];

    // slave state and logs (written by the slave only)
    int          ss[3], wcnt[3], beat[3], ar_cnt[3], acc_cnt[3];
    logic [31:0] ar_addr_log[3], ar_prev[3];
    logic [7:0]  arlen_log[3];
    logic [1:0]  arburst_log[3];
    logic [2:0]  arsize_log[3];
    logic [3:0]  arid_log[3];
    logic        ar_prev_v[3], ar_bad[3];

    int n_chk = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LW = (g == 0) ? 4 : (g == 1) ? 1 : 16;
        icache_burst #(.SETS(256), .LINE_WORDS(LW), .AXI_ID(0)) u_dut (
            .clk(clk), .reset(reset),
            .inst_sram_req(req[g]), .inst_sram_addr(addr[g]),
            .inst_sram_addr_ok(addr_ok[g]), .inst_sram_data_ok(dok[g]),
            .inst_sram_rdata(rd[g]), .flush(flush[g]),
            .hit_cnt(hitc[g]), .miss_cnt(missc[g]),
            .ARID(arid[g]), .ARADDR(araddr[g]), .ARLEN(arlen[g]), .ARSIZE(arsize[g]),
            .ARBURST(arburst[g]), .ARVALID(arvalid[g]), .ARREADY(arready[g]),
            .RID(4'd0), .RDATA(rdata_s[g]), .RRESP(rresp[g]), .RLAST(rlast[g]),
            .RVALID(rvalid[g]), .RREADY(rready[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                ss[i] <= 0; wcnt[i] <= 0; beat[i] <= 0;
                arready[i] <= 1'b0; rvalid[i] <= 1'b0; rlast[i] <= 1'b0;
                rdata_s[i] <= '0; rresp[i] <= 2'b00;
                ar_bad[i] <= 1'b0; ar_prev_v[i] <= 1'b0; ar_prev[i] <= '0;
            end else begin
                if (arvalid[i] && ar_prev_v[i] && araddr[i] != ar_prev[i])
                    ar_bad[i] <= 1'b1;
                ar_prev_v[i] <= arvalid[i] && !arready[i];
                ar_prev[i]   <= araddr[i];
                if (ss[i] == 0) begin
                    if (arvalid[i] && arready[i]) begin
                        arready[i] <= 1'b0;
                        ar_addr_log[i] <= araddr[i]; arlen_log[i] <= arlen[i];
                        arburst_log[i] <= arburst[i]; arsize_log[i] <= arsize[i];
                        arid_log[i] <= arid[i];
                        ar_cnt[i] <= ar_cnt[i] + 1;
                        beat[i] <= 0; wcnt[i] <= 0; ss[i] <= 1;
                    end else if (arvalid[i]) begin
                        if (wcnt[i] >= ar_delay[i]) arready[i] <= 1'b1;
                        else wcnt[i] <= wcnt[i] + 1;
                    end
                end else begin
                    if (rvalid[i] && rready[i]) begin
                        acc_cnt[i] <= acc_cnt[i] + 1;
                        if (beat[i] == int'(arlen_log[i])) begin
                            rvalid[i] <= 1'b0; ss[i] <= 0;
                        end else begin
                            beat[i] <= beat[i] + 1;
                            if (gap[i] != 0) rvalid[i] <= 1'b0;
                            else begin
                                rvalid[i]  <= 1'b1;
                                rdata_s[i] <= base[i] + 32'(beat[i] + 1);
                                rresp[i]   <= (beat[i] + 1 == err_beat[i]) ? 2'b10 : 2'b00;
                                rlast[i]   <= (beat[i] + 1 == int'(arlen_log[i]));
                            end
                        end
                    end else if (!rvalid[i]) begin
                        rvalid[i]  <= 1'b1;
                        rdata_s[i] <= base[i] + 32'(beat[i]);
                        rresp[i]   <= (beat[i] == err_beat[i]) ? 2'b10 : 2'b00;
                        rlast[i]   <= (beat[i] == int'(arlen_log[i]));
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fetch(input int g, input logic [31:0] a, output logic [31:0] d, output int lat);
        int n = 0;
        req[g] = 1'b1; addr[g] = a;
        while (!addr_ok[g] && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk); req[g] = 1'b0;
        lat = 1;
        while (!dok[g] && lat < 200) begin @(negedge clk); lat++; end
        d = rd[g];
    endtask

    // Fetch, check returned word and whether an AR burst was issued; hits must take exactly 2 cycles.
    task automatic xfetch(input string tag, input int g, input logic [31:0] a,
                          input logic [31:0] exp_d, input bit exp_miss);
        logic [31:0] d;
        int lat, ar0;
        ar0 = ar_cnt[g];
        fetch(g, a, d, lat);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_miss"}, 32'(ar_cnt[g] - ar0), exp_miss ? 32'd1 : 32'd0);
        if (!exp_miss) chk({tag, "_lat"}, 32'(lat), 32'd2);
    endtask

    initial begin
        int a0, d0, n;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; flush[i] = 1'b0; addr[i] = '0;
            ar_delay[i] = 0; gap[i] = 0; err_beat[i] = -1; base[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        chk("rst_hit", hitc[0], 32'd0);
        chk("rst_miss", missc[0], 32'd0);
        chk("rst_dok", {31'd0, dok[0]}, 32'd0);
        chk("rst_rdata", rd[0], 32'd0);
        chk("rst_arvalid", {31'd0, arvalid[0]}, 32'd0);
        chk("rst_rready", {31'd0, rready[0]}, 32'd0);
        chk("rst_addr_ok", {31'd0, addr_ok[0]}, 32'd1);

        // cold miss then hit in the same line
        base[0] = 32'hA0;
        xfetch("cold", 0, 32'h1C00_0008, 32'hA2, 1);
        chk("cold_araddr", ar_addr_log[0], 32'h1C00_0000);
        chk("cold_arlen", {24'd0, arlen_log[0]}, 32'd3);
        chk("cold_arburst", {30'd0, arburst_log[0]}, 32'd1);
        chk("cold_arsize", {29'd0, arsize_log[0]}, 32'd2);
        chk("cold_arid", {28'd0, arid_log[0]}, 32'd0);
        chk("cold_misscnt", missc[0], 32'd1);
        xfetch("hit", 0, 32'h1C00_000C, 32'hA3, 0);
        chk("hit_hitcnt", hitc[0], 32'd1);

        // conflict on index 0
        base[0] = 32'hB0;
        xfetch("conf1", 0, 32'h1C00_1000, 32'hB0, 1);
        base[0] = 32'hC0;
        xfetch("conf2", 0, 32'h1C00_0000, 32'hC0, 1);
        xfetch("conf_hit", 0, 32'h1C00_0004, 32'hC1, 0);
        chk("conf_misscnt", missc[0], 32'd3);

        // slow ARREADY, gapped beats
        ar_delay[0] = 5; gap[0] = 1; base[0] = 32'hD0;
        a0 = acc_cnt[0]; d0 = 0;
        fork
            xfetch("stall", 0, 32'h1C00_0100, 32'hD0, 1);
            begin
                n = 0;
                while (n < 300) begin @(negedge clk); if (dok[0]) d0++; n++; end
            end
        join
        chk("stall_beats", 32'(acc_cnt[0] - a0), 32'd4);
        chk("stall_dok_cnt", 32'(d0), 32'd1);
        chk("stall_ar_stable", {31'd0, ar_bad[0]}, 32'd0);
        ar_delay[0] = 0;
        xfetch("stall_w1", 0, 32'h1C00_0104, 32'hD1, 0);
        xfetch("stall_w2", 0, 32'h1C00_0108, 32'hD2, 0);
        xfetch("stall_w3", 0, 32'h1C00_010C, 32'hD3, 0);

        // flush during refill
        base[0] = 32'hE0; a0 = acc_cnt[0];
        fork
            xfetch("flush", 0, 32'h1C00_0208, 32'hE2, 1);
            begin
                n = 0;
                while (acc_cnt[0] < a0 + 2 && n < 200) begin @(negedge clk); n++; end
                flush[0] = 1'b1; #1;
                chk("flush_aok0", {31'd0, addr_ok[0]}, 32'd0);
                @(negedge clk); flush[0] = 1'b0; #1;
                chk("flush_aok_pend", {31'd0, addr_ok[0]}, 32'd0);
            end
        join
        chk("flush_aok_after", {31'd0, addr_ok[0]}, 32'd1);
        base[0] = 32'hF0;
        xfetch("flush_refetch", 0, 32'h1C00_0208, 32'hF2, 1);
        base[0] = 32'h90;
        xfetch("flush_other", 0, 32'h1C00_000C, 32'h93, 1);

        // flush and request together in IDLE
        req[0] = 1'b1; addr[0] = 32'h1C00_0000; flush[0] = 1'b1; #1;
        chk("flreq_aok", {31'd0, addr_ok[0]}, 32'd0);
        @(negedge clk); req[0] = 1'b0; flush[0] = 1'b0; #1;
        chk("flreq_idle", {31'd0, addr_ok[0]}, 32'd1);

        // error response leaves the line invalid
        base[0] = 32'h50; err_beat[0] = 1; gap[0] = 0;
        xfetch("err", 0, 32'h1C00_0304, 32'h51, 1);
        err_beat[0] = -1;
        xfetch("err_refetch", 0, 32'h1C00_0304, 32'h51, 1);
        xfetch("err_hit", 0, 32'h1C00_0308, 32'h52, 0);
        chk("end_misscnt", missc[0], 32'd9);
        chk("end_hitcnt", hitc[0], 32'd6);

        // single-word lines
        base[1] = 32'h70; err_beat[1] = 0;
        xfetch("lw1_err", 1, 32'h2000_0010, 32'h70, 1);
        chk("lw1_arlen", {24'd0, arlen_log[1]}, 32'd0);
        chk("lw1_araddr", ar_addr_log[1], 32'h2000_0010);
        err_beat[1] = -1;
        xfetch("lw1_refetch", 1, 32'h2000_0010, 32'h70, 1);
        xfetch("lw1_hit", 1, 32'h2000_0010, 32'h70, 0);

        // sixteen-word lines
        base[2] = 32'h300; err_beat[2] = 1;
        xfetch("lw16_err", 2, 32'h3000_0024, 32'h309, 1);
        chk("lw16_arlen", {24'd0, arlen_log[2]}, 32'd15);
        chk("lw16_araddr", ar_addr_log[2], 32'h3000_0000);
        err_beat[2] = -1;
        xfetch("lw16_refetch", 2, 32'h3000_0024, 32'h309, 1);
        xfetch("lw16_hit", 2, 32'h3000_003C, 32'h30F, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
